// File: rtl/alu_wb_buffer.sv
// Writeback-side result queue for the ALU. It accepts one result per cycle and
// presents the oldest entry first-word-fall-through to a valid/ack writeback port.
module alu_wb_buffer #(
    parameter int XLEN          = 64,
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       alu_valid_i,
    input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
    input  logic [XLEN-1:0]            alu_result_i,
    input  logic                       alu_branch_res_i,
    output logic                       alu_ready_o,
    output logic                       drop_o,
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic                       wb_branch_res_o,
    input  logic                       wb_ack_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]          mem_result [DEPTH];
    logic [TRANS_ID_BITS-1:0] mem_id     [DEPTH];
    logic                     mem_br     [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             drop;
    logic             not_empty;
    logic             not_full;
    logic             push;
    logic             pop;

    // Readiness depends only on occupancy, so an ack never opens a slot in the same cycle.
    assign not_full  = (count != FULL_COUNT);
    assign not_empty = (count != '0);
    assign push      = alu_valid_i & not_full & ~flush_i;
    assign pop       = not_empty & wb_ack_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= alu_valid_i & ~not_full & ~flush_i;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is not reset; empty slots are never observable because outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_result[wr_ptr] <= alu_result_i;
            mem_id[wr_ptr]     <= alu_trans_id_i;
            mem_br[wr_ptr]     <= alu_branch_res_i;
        end
    end

    always_comb begin
        wb_trans_id_o   = '0;
        wb_result_o     = '0;
        wb_branch_res_o = 1'b0;
        if (not_empty) begin
            wb_trans_id_o   = mem_id[rd_ptr];
            wb_result_o     = mem_result[rd_ptr];
            wb_branch_res_o = mem_br[rd_ptr];
        end
    end

    assign alu_ready_o = not_full;
    assign wb_valid_o  = not_empty;
    assign drop_o      = drop;
    assign count_o     = count;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_wb_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int IDW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            alu_valid;
    logic [IDW-1:0]  alu_id;
    logic [XLEN-1:0] alu_res;
    logic            alu_br;
    logic            alu_ready;
    logic            drop;
    logic            wb_valid;
    logic [IDW-1:0]  wb_id;
    logic [XLEN-1:0] wb_res;
    logic            wb_br;
    logic            wb_ack;
    logic [2:0]      count;

    alu_wb_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TRANS_ID_BITS(IDW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .alu_valid_i      (alu_valid),
        .alu_trans_id_i   (alu_id),
        .alu_result_i     (alu_res),
        .alu_branch_res_i (alu_br),
        .alu_ready_o      (alu_ready),
        .drop_o           (drop),
        .wb_valid_o       (wb_valid),
        .wb_trans_id_o    (wb_id),
        .wb_result_o      (wb_res),
        .wb_branch_res_o  (wb_br),
        .wb_ack_i         (wb_ack),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] res;
        logic            br;
    } entry_t;

    entry_t exp_q[$];
    bit     exp_drop = 1'b0;
    int     compared = 0;
    int     mismatched = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model: checks what the DUT presents, then advances the
    // model with the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_count", 64'(count), 64'd0);
            check("rst_valid", 64'(wb_valid), 64'd0);
            check("rst_ready", 64'(alu_ready), 64'd1);
            check("rst_drop", 64'(drop), 64'd0);
            exp_q.delete();
            exp_drop = 1'b0;
        end else begin
            bit full;
            full = (exp_q.size() == DEPTH);
            check("count", 64'(count), 64'(exp_q.size()));
            check("ready", 64'(alu_ready), 64'(!full));
            check("valid", 64'(wb_valid), 64'(exp_q.size() != 0));
            check("drop", 64'(drop), 64'(exp_drop));
            if (exp_q.size() != 0) begin
                check("wb_id", 64'(wb_id), 64'(exp_q[0].id));
                check("wb_result", wb_res, exp_q[0].res);
                check("wb_branch", 64'(wb_br), 64'(exp_q[0].br));
            end else begin
                check("idle_data", {wb_res[XLEN-5:0], wb_id, wb_br}, 64'd0);
            end
            exp_drop = alu_valid && full && !flush;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && wb_ack) void'(exp_q.pop_front());
                if (alu_valid && !full) exp_q.push_back('{id: alu_id, res: alu_res, br: alu_br});
            end
        end
    end

    task automatic step(input bit v, input int id, input logic [XLEN-1:0] res, input bit br,
                        input bit ack, input bit fl);
        alu_valid = v;
        alu_id    = IDW'(id);
        alu_res   = res;
        alu_br    = br;
        wb_ack    = ack;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 0, '0, 1'b0, ack, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; alu_valid = 1'b0; alu_id = '0; alu_res = '0; alu_br = 1'b0; wb_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_count", 64'(count), 64'd0);
        check("init_ready", 64'(alu_ready), 64'd1);
        rst = 1'b0;
        idle(1'b0);

        // single entry, held until acked
        step(1'b1, 5, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        check("single_valid", 64'(wb_valid), 64'd1);
        check("single_id", 64'(wb_id), 64'd5);
        repeat (3) idle(1'b0);
        check("single_hold", wb_res, 64'hDEAD_BEEF);
        idle(1'b1);
        check("single_drained", 64'(count), 64'd0);

        // fill to full, refused fifth push, drain in order
        for (int i = 0; i < 4; i++) step(1'b1, i, 64'(i * 17 + 3), i[0], 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(alu_ready), 64'd0);
        step(1'b1, 4, 64'h4444, 1'b0, 1'b0, 1'b0);
        check("full_drop", 64'(drop), 64'd1);
        check("full_keep", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_id", 64'(wb_id), 64'(i));
            idle(1'b1);
        end
        check("drain_empty", 64'(count), 64'd0);

        // steady push+ack at count 2 across pointer wrap
        step(1'b1, 0, 64'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1, 64'h101, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 22; i++) begin
            step(1'b1, i, 64'(256 + i), i[0], 1'b1, 1'b0);
            check("conc_count", 64'(count), 64'd2);
            check("conc_id", 64'(wb_id), 64'((i - 1) % 8));
        end
        idle(1'b1);
        idle(1'b1);

        // flush with simultaneous push and ack
        for (int i = 0; i < 3; i++) step(1'b1, i + 1, 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 6, 64'h66, 1'b1, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(wb_valid), 64'd0);
        step(1'b1, 7, 64'h77, 1'b1, 1'b0, 1'b0);
        check("post_flush_count", 64'(count), 64'd1);
        check("post_flush_id", 64'(wb_id), 64'd7);
        idle(1'b1);

        // asynchronous reset mid-operation
        step(1'b1, 2, 64'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3, 64'h33, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_valid", 64'(wb_valid), 64'd0);
        check("async_ready", 64'(alu_ready), 64'd1);
        alu_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b0);

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
        end
        repeat (6) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
